// File: rtl/div_sequencer_if.sv
// div_sequencer_if
//   Bundles the request/result side and the divider-core side of the divide
//   sequencer into one interface.
//   slave  : view used by div_sequencer (consumes requests, drives the core)
//   master : view used by the environment (issues requests, models the core)
//   Signals: ctrl_DIV, data_operandA/B, data_result, data_exception,
//            data_resultRDY, busy, core_start, core_dividend, core_divisor,
//            core_ready, core_quotient, core_remainder,
//            data_remainder (only when DIV_REMAINDER_EN is defined)
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
    logic             core_start;
    logic [WIDTH-1:0] core_dividend;
    logic [WIDTH-1:0] core_divisor;
    logic             core_ready;
    logic [WIDTH-1:0] core_quotient;
    logic [WIDTH-1:0] core_remainder;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] data_remainder;
`endif

    modport slave (
`ifdef DIV_REMAINDER_EN
        input  core_remainder,
        output data_remainder,
`endif
        input  ctrl_DIV, data_operandA, data_operandB,
        input  core_ready, core_quotient,
        output data_result, data_exception, data_resultRDY, busy,
        output core_start, core_dividend, core_divisor
    );

    modport master (
`ifdef DIV_REMAINDER_EN
        output core_remainder,
        input  data_remainder,
`endif
        output ctrl_DIV, data_operandA, data_operandB,
        output core_ready, core_quotient,
        input  data_result, data_exception, data_resultRDY, busy,
        input  core_start, core_dividend, core_divisor
    );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer
//   Front-end sequencer for the iterative unsigned divider core. Accepts a
//   signed divide request, flags divide-by-zero, hands operand magnitudes to
//   the core with a one-cycle start pulse, waits (under a watchdog) for the
//   core's ready, restores the quotient sign and strobes data_resultRDY.
//   Parameters: WIDTH (operand width), MAX_WAIT (WAIT cycles before timeout)
//   Ports:
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      div_sequencer_if.slave (request, result and core handshake)
//   Optional feature: define DIV_REMAINDER_EN to add the signed remainder
//   output (data_remainder, sign follows the dividend).
module div_sequencer #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic            clock,
    input  logic            reset_n,
    div_sequencer_if.slave  bus
);
    localparam int WD_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        FIXUP,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WD_W-1:0]  wdog;
    logic             wd_expired;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] result_q;
    logic             exception_q;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] remainder_q;
`endif

    assign wd_expired = (wdog == WD_W'(MAX_WAIT - 1));

    always_comb begin
        state_next = state;
        case (state)
            // Divide-by-zero passes through FIXUP so its result strobe lands
            // on the same second cycle as the normal post-ready path.
            IDLE:    if (bus.ctrl_DIV)
                         state_next = (bus.data_operandB == '0) ? FIXUP : LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (bus.core_ready)
                         state_next = FIXUP;
                     else if (wd_expired)
                         state_next = DONE;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wdog        <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            div_zero    <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            result_q    <= '0;
            exception_q <= 1'b0;
`ifdef DIV_REMAINDER_EN
            remainder_q <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.ctrl_DIV) begin
                        sign_a   <= bus.data_operandA[WIDTH-1];
                        sign_b   <= bus.data_operandB[WIDTH-1];
                        div_zero <= (bus.data_operandB == '0);
                        // Most-negative value maps to itself, which reads
                        // correctly as an unsigned magnitude.
                        mag_a    <= bus.data_operandA[WIDTH-1] ? -bus.data_operandA
                                                               : bus.data_operandA;
                        mag_b    <= bus.data_operandB[WIDTH-1] ? -bus.data_operandB
                                                               : bus.data_operandB;
                    end
                end
                LAUNCH: begin
                    wdog <= '0;
                end
                WAIT: begin
                    if (!bus.core_ready) begin
                        if (wd_expired) begin
                            result_q    <= '0;
                            exception_q <= 1'b1;
`ifdef DIV_REMAINDER_EN
                            remainder_q <= '0;
`endif
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
                    end
                end
                FIXUP: begin
                    if (div_zero) begin
                        result_q    <= '0;
                        exception_q <= 1'b1;
`ifdef DIV_REMAINDER_EN
                        remainder_q <= '0;
`endif
                    end else begin
                        result_q    <= (sign_a ^ sign_b) ? -bus.core_quotient
                                                         : bus.core_quotient;
                        exception_q <= 1'b0;
`ifdef DIV_REMAINDER_EN
                        remainder_q <= sign_a ? -bus.core_remainder
                                              : bus.core_remainder;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.core_start     = (state == LAUNCH);
    assign bus.data_resultRDY = (state == DONE);
    assign bus.busy           = (state != IDLE);
    assign bus.core_dividend  = mag_a;
    assign bus.core_divisor   = mag_b;
    assign bus.data_result    = result_q;
    assign bus.data_exception = exception_q;
`ifdef DIV_REMAINDER_EN
    assign bus.data_remainder = remainder_q;
`endif
endmodule
